// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM states, oversampling
// constants and small bit-level helper functions.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam int unsigned TICKS_PER_BIT = 16;
    localparam logic [3:0]  TICK_LAST     = 4'(TICKS_PER_BIT - 1);
    localparam logic [3:0]  SAMPLE_LO     = 4'd7;
    localparam logic [3:0]  SAMPLE_MID    = 4'd8;
    localparam logic [3:0]  SAMPLE_HI     = 4'd9;
    localparam logic [3:0]  STOP_EXIT     = 4'd9;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // High when data plus received parity bit disagree with the selected sense.
    function automatic logic parity_mismatch(input logic [7:0] data,
                                             input logic       par_bit,
                                             input logic       odd);
        return ((^data) ^ par_bit) != odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous rxd line plus a
// falling-edge detector on the synchronized value.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxd_sync,
    output logic rxd_fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;

    // Shift the raw line in; the edge flop keeps the previous synchronized value.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rxd};
        edge_d = sync_q[SYNC_STAGES-1];
    end

    // Reset to the idle-high level so release never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {SYNC_STAGES{1'b1}};
            edge_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            edge_q <= edge_d;
        end
    end

    assign rxd_sync = sync_q[SYNC_STAGES-1];
    assign rxd_fall = edge_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver with optional parity, 2-of-3 majority
// voting per bit and a single-entry holding register with overrun flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       baud16,
    input  logic       rxd,
    input  logic       parity_en,
    input  logic       parity_odd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    input  logic       ovr_clr
);

    rx_state_e  state_q, state_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] samp_q, samp_d;
    logic       par_err_q, par_err_d;
    logic       baud16_d_q;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       parity_err_q, parity_err_d;
    logic       overrun_q, overrun_d;

    logic       rxd_s, rxd_fall_s, tick_s, vote_s, load_s;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .rxd_sync (rxd_s),
        .rxd_fall (rxd_fall_s)
    );

    assign tick_s = baud16 & ~baud16_d_q;

    // Receive FSM: oversample counting, voting, shifting and load request.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        samp_d     = samp_q;
        par_err_d  = par_err_q;
        load_s     = 1'b0;
        // STOP decides on its last sample tick, so that sample is taken live.
        vote_s     = (state_q == ST_STOP) ? majority3({rxd_s, samp_q[1:0]})
                                          : majority3(samp_q);
        if (!en) begin
            state_d    = ST_IDLE;
            tick_cnt_d = 4'd0;
        end else if (state_q == ST_IDLE) begin
            if (rxd_fall_s) begin
                state_d    = ST_START;
                tick_cnt_d = 4'd0;
                par_err_d  = 1'b0;
            end else begin
                state_d    = ST_IDLE;
            end
        end else if (tick_s) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
            case (tick_cnt_q)
                SAMPLE_LO:  samp_d[0] = rxd_s;
                SAMPLE_MID: samp_d[1] = rxd_s;
                SAMPLE_HI:  samp_d[2] = rxd_s;
                default:    samp_d    = samp_q;
            endcase
            case (state_q)
                ST_START: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        state_d   = vote_s ? ST_IDLE : ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        state_d   = ST_START;
                    end
                end
                ST_DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        shift_d[bit_cnt_q] = vote_s;
                        bit_cnt_d          = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = parity_en ? ST_PARITY : ST_STOP;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        par_err_d = parity_mismatch(shift_q, vote_s, parity_odd);
                        state_d   = ST_STOP;
                    end else begin
                        state_d   = ST_PARITY;
                    end
                end
                ST_STOP: begin
                    if (tick_cnt_q == STOP_EXIT) begin
                        load_s  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_STOP;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Holding register, consumer handshake and sticky overrun.
    always_comb begin
        rx_data_d    = rx_data_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        rx_valid_d   = rx_valid_q;
        overrun_d    = overrun_q;
        if (load_s) begin
            rx_data_d    = shift_q;
            frame_err_d  = ~vote_s;
            parity_err_d = parity_en & par_err_q;
            rx_valid_d   = 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d   = 1'b0;
        end else begin
            rx_valid_d   = rx_valid_q;
        end
        if (load_s && rx_valid_q && !rx_ready) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= 4'd0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            samp_q       <= 3'd0;
            par_err_q    <= 1'b0;
            baud16_d_q   <= 1'b0;
            rx_data_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            samp_q       <= samp_d;
            par_err_q    <= par_err_d;
            baud16_d_q   <= baud16;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: 4-clk baud16 period (64 clk per bit), frames
// driven bit by bit, delivered bytes captured on handshake and compared.
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst, en, baud16, rxd, parity_en, parity_odd, rx_ready, ovr_clr;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, overrun;

    int         cmp_cnt = 0;
    int         err_cnt = 0;
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    logic [9:0] exp_v, got_v;

    uart_rx #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .en(en), .baud16(baud16), .rxd(rxd),
        .parity_en(parity_en), .parity_odd(parity_odd),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .parity_err(parity_err),
        .overrun(overrun), .ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    initial begin
        baud16 = 1'b0;
        forever begin
            repeat (2) @(posedge clk);
            #1;
            baud16 = ~baud16;
        end
    end

    // Record every transfer the consumer accepts: {data, frame_err, parity_err}.
    always @(negedge clk) begin
        if (rst && rx_valid && rx_ready) got_q.push_back({rx_data, frame_err, parity_err});
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        step(64);
    endtask

    // pmode: 0 = no parity bit, 1 = correct parity bit, 2 = inverted parity bit
    task automatic send_frame(input logic [7:0] data, input int pmode, input logic stop);
        logic pbit;
        pbit = parity_odd ? ~(^data) : (^data);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        if (pmode == 1) send_bit(pbit);
        if (pmode == 2) send_bit(~pbit);
        send_bit(stop);
        rxd = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        #2;
        cmp_cnt++;
        if ({rx_data, rx_valid, frame_err, parity_err, overrun} !== 12'h000) begin
            err_cnt++;
            $display("FAIL reset_outputs: got data=%h v=%b fe=%b pe=%b ovr=%b, expected all 0",
                     rx_data, rx_valid, frame_err, parity_err, overrun);
        end
        step(3);
        rst = 1'b1;
        step(20);
        cmp_cnt++;
        if (dut.state_q !== ST_IDLE || got_q.size() != 0) begin
            err_cnt++;
            $display("FAIL reset_release: state=%0d frames=%0d, expected IDLE and 0", dut.state_q, got_q.size());
        end
    endtask

    task automatic test_no_parity;
        parity_en = 1'b0;
        exp_q.push_back({8'hA5, 1'b0, 1'b0});
        send_frame(8'hA5, 0, 1'b1);
        step(16);
        while (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            cmp_cnt++;
            if (got_q.size() == 0) begin
                err_cnt++;
                $display("FAIL no_parity: no frame, expected data=%h fe=%b pe=%b", exp_v[9:2], exp_v[1], exp_v[0]);
            end else begin
                got_v = got_q.pop_front();
                if (got_v !== exp_v) begin
                    err_cnt++;
                    $display("FAIL no_parity: got data=%h fe=%b pe=%b, expected data=%h fe=%b pe=%b",
                             got_v[9:2], got_v[1], got_v[0], exp_v[9:2], exp_v[1], exp_v[0]);
                end
            end
        end
    endtask

    task automatic test_parity_err;
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        exp_q.push_back({8'h3C, 1'b0, 1'b1});
        send_frame(8'h3C, 2, 1'b1);
        step(16);
        while (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            cmp_cnt++;
            if (got_q.size() == 0) begin
                err_cnt++;
                $display("FAIL parity_err: no frame, expected data=%h fe=%b pe=%b", exp_v[9:2], exp_v[1], exp_v[0]);
            end else begin
                got_v = got_q.pop_front();
                if (got_v !== exp_v) begin
                    err_cnt++;
                    $display("FAIL parity_err: got data=%h fe=%b pe=%b, expected data=%h fe=%b pe=%b",
                             got_v[9:2], got_v[1], got_v[0], exp_v[9:2], exp_v[1], exp_v[0]);
                end
            end
        end
        parity_en = 1'b0;
    endtask

    task automatic test_false_start;
        rxd = 1'b0;
        step(12);
        rxd = 1'b1;
        step(100);
        cmp_cnt++;
        if (got_q.size() != 0) begin
            err_cnt++;
            $display("FAIL false_start_frames: got %0d frames, expected 0", got_q.size());
            got_q.delete();
        end
        cmp_cnt++;
        if (dut.state_q !== ST_IDLE) begin
            err_cnt++;
            $display("FAIL false_start_state: got state %0d, expected %0d", dut.state_q, ST_IDLE);
        end
    endtask

    task automatic test_frame_err;
        parity_en = 1'b0;
        exp_q.push_back({8'h55, 1'b1, 1'b0});
        send_frame(8'h55, 0, 1'b0);
        step(64);
        while (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            cmp_cnt++;
            if (got_q.size() == 0) begin
                err_cnt++;
                $display("FAIL frame_err: no frame, expected data=%h fe=%b pe=%b", exp_v[9:2], exp_v[1], exp_v[0]);
            end else begin
                got_v = got_q.pop_front();
                if (got_v !== exp_v) begin
                    err_cnt++;
                    $display("FAIL frame_err: got data=%h fe=%b pe=%b, expected data=%h fe=%b pe=%b",
                             got_v[9:2], got_v[1], got_v[0], exp_v[9:2], exp_v[1], exp_v[0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] data_tbl [4] = '{8'h01, 8'hFE, 8'h80, 8'h00};
        int         mode_tbl [4] = '{1, 1, 2, 1};
        parity_en  = 1'b1;
        parity_odd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({data_tbl[i], 1'b0, (mode_tbl[i] == 2)});
            send_frame(data_tbl[i], mode_tbl[i], 1'b1);
        end
        step(16);
        while (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            cmp_cnt++;
            if (got_q.size() == 0) begin
                err_cnt++;
                $display("FAIL back_to_back: no frame, expected data=%h fe=%b pe=%b", exp_v[9:2], exp_v[1], exp_v[0]);
            end else begin
                got_v = got_q.pop_front();
                if (got_v !== exp_v) begin
                    err_cnt++;
                    $display("FAIL back_to_back: got data=%h fe=%b pe=%b, expected data=%h fe=%b pe=%b",
                             got_v[9:2], got_v[1], got_v[0], exp_v[9:2], exp_v[1], exp_v[0]);
                end
            end
        end
        parity_en  = 1'b0;
        parity_odd = 1'b0;
    endtask

    task automatic test_enable_abort;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        en  = 1'b0;
        rxd = 1'b1;
        step(2);
        cmp_cnt++;
        if (dut.state_q !== ST_IDLE) begin
            err_cnt++;
            $display("FAIL enable_abort_state: got state %0d, expected %0d", dut.state_q, ST_IDLE);
        end
        step(10);
        en = 1'b1;
        step(700);
        cmp_cnt++;
        if (got_q.size() != 0) begin
            err_cnt++;
            $display("FAIL enable_abort_frames: got %0d frames, expected 0", got_q.size());
            got_q.delete();
        end
    endtask

    task automatic test_overrun;
        rx_ready = 1'b0;
        send_frame(8'h11, 0, 1'b1);
        cmp_cnt++;
        if ({rx_valid, rx_data, overrun} !== {1'b1, 8'h11, 1'b0}) begin
            err_cnt++;
            $display("FAIL overrun_first: got v=%b data=%h ovr=%b, expected v=1 data=11 ovr=0", rx_valid, rx_data, overrun);
        end
        send_frame(8'h22, 0, 1'b1);
        step(8);
        cmp_cnt++;
        if ({rx_valid, rx_data, overrun} !== {1'b1, 8'h22, 1'b1}) begin
            err_cnt++;
            $display("FAIL overrun_second: got v=%b data=%h ovr=%b, expected v=1 data=22 ovr=1", rx_valid, rx_data, overrun);
        end
        ovr_clr = 1'b1;
        step(1);
        ovr_clr = 1'b0;
        cmp_cnt++;
        if ({rx_valid, overrun} !== 2'b10) begin
            err_cnt++;
            $display("FAIL overrun_clear: got v=%b ovr=%b, expected v=1 ovr=0", rx_valid, overrun);
        end
        exp_q.push_back({8'h22, 1'b0, 1'b0});
        rx_ready = 1'b1;
        step(4);
        while (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            cmp_cnt++;
            if (got_q.size() != 1) begin
                err_cnt++;
                $display("FAIL overrun_drain: got %0d frames, expected 1 with data=%h", got_q.size(), exp_v[9:2]);
                got_q.delete();
            end else begin
                got_v = got_q.pop_front();
                if (got_v !== exp_v) begin
                    err_cnt++;
                    $display("FAIL overrun_drain: got data=%h fe=%b pe=%b, expected data=%h fe=%b pe=%b",
                             got_v[9:2], got_v[1], got_v[0], exp_v[9:2], exp_v[1], exp_v[0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rst = 1'b0;
        rxd = 1'b1;
        #2;
        cmp_cnt++;
        if ({rx_data, rx_valid, frame_err, parity_err, overrun} !== 12'h000) begin
            err_cnt++;
            $display("FAIL midframe_reset_async: got data=%h v=%b fe=%b pe=%b ovr=%b, expected all 0",
                     rx_data, rx_valid, frame_err, parity_err, overrun);
        end
        step(5);
        rst = 1'b1;
        step(10);
        cmp_cnt++;
        if (dut.state_q !== ST_IDLE || got_q.size() != 0) begin
            err_cnt++;
            $display("FAIL midframe_reset_idle: state=%0d frames=%0d, expected IDLE and 0", dut.state_q, got_q.size());
            got_q.delete();
        end
        exp_q.push_back({8'h0F, 1'b0, 1'b0});
        send_frame(8'h0F, 0, 1'b1);
        step(16);
        while (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            cmp_cnt++;
            if (got_q.size() == 0) begin
                err_cnt++;
                $display("FAIL midframe_reset_frame: no frame, expected data=%h", exp_v[9:2]);
            end else begin
                got_v = got_q.pop_front();
                if (got_v !== exp_v) begin
                    err_cnt++;
                    $display("FAIL midframe_reset_frame: got data=%h fe=%b pe=%b, expected data=%h fe=%b pe=%b",
                             got_v[9:2], got_v[1], got_v[0], exp_v[9:2], exp_v[1], exp_v[0]);
                end
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        rxd        = 1'b1;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        rx_ready   = 1'b1;
        ovr_clr    = 1'b0;
        test_reset;
        test_no_parity;
        test_parity_err;
        test_false_start;
        test_frame_err;
        test_back_to_back;
        test_enable_abort;
        test_overrun;
        test_reset_mid_frame;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
